// File: rtl/cog_ram_dp_if.sv
// Port A (read/write) and port B (read-only) bundle for the cog register RAM.
interface cog_ram_dp_if #(
  parameter int DW = 32,
  parameter int AW = 9
);
  logic            a_ena;
  logic            a_w;
  logic [DW/8-1:0] a_be;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_d;
  logic [DW-1:0]   a_q;
  logic            b_ena;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_q;

  modport master (
    output a_ena, a_w, a_be, a_addr, a_d, b_ena, b_addr,
    input  a_q, b_q
  );

  modport slave (
    input  a_ena, a_w, a_be, a_addr, a_d, b_ena, b_addr,
    output a_q, b_q
  );
endinterface

// File: rtl/cog_ram_dp.sv
// Dual-port cog register RAM: byte-enabled R/W port A, read-only port B,
// built-in clear sweep after reset or on request, optional output register.
module cog_ram_dp #(
  parameter int            DW      = 32,
  parameter int            AW      = 9,
  parameter bit            OUT_REG = 1'b0,
  parameter bit            RDW_NEW = 1'b0,
  parameter logic [DW-1:0] INIT    = '0
) (
  input  logic         clk,
  input  logic         nres,
  input  logic         clr,
  output logic         busy,
  cog_ram_dp_if.slave  bus
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state, state_nx;
  logic [AW:0]   ptr, ptr_nx;
  logic [NB-1:0] wr_be;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          user_wr;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] a_old, b_old, a_mrg, b_mrg, a_rd, b_rd;
  logic [DW-1:0] a_s1, b_s1;

  always_ff @(posedge clk) begin
    if (!nres) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // The sweep owns the write port while busy; otherwise port A does.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    user_wr  = 1'b0;
    wr_be    = '0;
    wr_addr  = bus.a_addr;
    wr_data  = bus.a_d;
    case (state)
      CLEAR: begin
        ptr_nx  = ptr + (AW+1)'(1);
        wr_be   = '1;
        wr_addr = ptr[AW-1:0];
        wr_data = INIT;
        if (ptr == (AW+1)'(DEPTH-1)) state_nx = IDLE;
      end
      IDLE: begin
        user_wr = bus.a_ena & bus.a_w;
        if (user_wr) wr_be = bus.a_be;
        if (clr) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (nres) begin
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign a_old = mem[bus.a_addr];
  assign b_old = mem[bus.b_addr];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign a_mrg[8*i +: 8] = bus.a_be[i] ? bus.a_d[8*i +: 8] : a_old[8*i +: 8];
    assign b_mrg[8*i +: 8] = bus.a_be[i] ? bus.a_d[8*i +: 8] : b_old[8*i +: 8];
  end

  assign a_rd = (RDW_NEW && user_wr) ? a_mrg : a_old;
  assign b_rd = (RDW_NEW && user_wr && (bus.b_addr == bus.a_addr)) ? b_mrg : b_old;

  always_ff @(posedge clk) begin
    if (!nres) begin
      a_s1 <= '0;
      b_s1 <= '0;
    end else if (state == IDLE) begin
      if (bus.a_ena) a_s1 <= a_rd;
      if (bus.b_ena) b_s1 <= b_rd;
    end
  end

  if (OUT_REG) begin : g_oreg
    logic [DW-1:0] a_s2, b_s2;
    always_ff @(posedge clk) begin
      if (!nres) begin
        a_s2 <= '0;
        b_s2 <= '0;
      end else if (state == IDLE) begin
        a_s2 <= a_s1;
        b_s2 <= b_s1;
      end
    end
    assign bus.a_q = a_s2;
    assign bus.b_q = b_s2;
  end else begin : g_noreg
    assign bus.a_q = a_s1;
    assign bus.b_q = b_s1;
  end
endmodule
